vga_write_arbiter: RTL and testbench

Shares the single vga_adapter pixel-write port between up to NREQ drawing engines (player ship, enemies, shots, score). Each engine requests the port, receives a grant for a whole erase/redraw burst, and streams pixels through it. Arbitration is round-robin across bursts, with an optional watchdog on hold time. Sits between the object instances and vga_adapter in the top level.

---
 rtl/vga_write_arbiter_if.sv | 39 +++
 rtl/vga_write_arbiter.sv | 108 ++++++++++
 tb/tb_vga_write_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vga_write_arbiter_if.sv
// Pixel-write bus between the drawing engines and the arbiter that owns the
// single vga_adapter write port.
//   req/req_write/req_x/req_y/req_color : packed per-requester request side
//   gnt                                 : one-hot grant back to the engines
//   VGA_x/VGA_y/VGA_color/VGA_write     : registered pixel port to vga_adapter
//   busy/owner/timeout/drop_err         : arbiter status
// The slave modport is the arbiter, the master modport is the engine side.
interface vga_write_arbiter_if #(
  parameter int NREQ = 4,
  parameter int nX   = 10,
  parameter int nY   = 9,
  parameter int CW   = 9,
  parameter int IDXW = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*nX-1:0] req_x;
  logic [NREQ*nY-1:0] req_y;
  logic [NREQ*CW-1:0] req_color;
  logic [NREQ-1:0]    gnt;
  logic [nX-1:0]      VGA_x;
  logic [nY-1:0]      VGA_y;
  logic [CW-1:0]      VGA_color;
  logic               VGA_write;
  logic               busy;
  logic [IDXW-1:0]    owner;
  logic               timeout;
  logic               drop_err;

  modport master (
    output req, req_write, req_x, req_y, req_color,
    input  gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy, owner, timeout, drop_err
  );

  modport slave (
    input  req, req_write, req_x, req_y, req_color,
    output gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy, owner, timeout, drop_err
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port between up to
// NREQ drawing engines. A grant covers a whole burst; after each burst a
// single RELEASE cycle lets the owner see gnt fall before anyone is re-granted.
// An optional watchdog (MAX_HOLD != 0) revokes a grant held too long.
// Ports:
//   Clock  : system clock
//   Resetn : asynchronous active-low reset
//   bus    : slave side of vga_write_arbiter_if (requests in, grant/pixel/status out)
module vga_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int nX       = 10,
  parameter int nY       = 9,
  parameter int CW       = 9,
  parameter int MAX_HOLD = 0,
  parameter int IDXW     = 2
) (
  input logic              Clock,
  input logic              Resetn,
  vga_write_arbiter_if.slave bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] owner_q;
  logic [IDXW-1:0] winner;
  logic            win_vld;
  logic [HW-1:0]   hold;
  logic            hold_hit;
  logic [NREQ-1:0] gnt_q;

  // Scan from the slot after the last owner with wrap; first set bit wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(owner_q) + k) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        winner  = IDXW'(idx);
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (hold == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = GRANT;
      GRANT:   if (!bus.req[owner_q] || hold_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Registered grant, pixel port and status
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      owner_q       <= IDXW'(NREQ - 1);
      hold          <= '0;
      gnt_q         <= '0;
      bus.VGA_x     <= '0;
      bus.VGA_y     <= '0;
      bus.VGA_color <= '0;
      bus.VGA_write <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.drop_err  <= 1'b0;
    end else begin
      if (state == IDLE && win_vld) owner_q <= winner;

      if (state != GRANT)       hold <= '0;
      else if (hold != HOLD_LAST) hold <= hold + 1'b1;

      if (state_nxt != GRANT)   gnt_q <= '0;
      else if (state == IDLE)   gnt_q <= NREQ'(1) << winner;

      // Coordinates follow the owner only while granted and hold otherwise.
      if (state == GRANT) begin
        bus.VGA_x     <= bus.req_x[int'(owner_q)*nX +: nX];
        bus.VGA_y     <= bus.req_y[int'(owner_q)*nY +: nY];
        bus.VGA_color <= bus.req_color[int'(owner_q)*CW +: CW];
      end
      bus.VGA_write <= (state == GRANT) && bus.req_write[owner_q];

      bus.timeout   <= (state == GRANT) && hold_hit;

      // gnt is exactly the owner's bit while in GRANT and zero elsewhere,
      // so any write outside it comes from a requester without the port.
      bus.drop_err  <= bus.drop_err | (|(bus.req_write & ~gnt_q));
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_write_arbiter_if #(.NREQ(4), .nX(10), .nY(9), .CW(9), .IDXW(2)) bus8();
  vga_write_arbiter_if #(.NREQ(4), .nX(10), .nY(9), .CW(9), .IDXW(2)) bus0();

  // The MAX_HOLD=0 instance sees the same requests as the watchdog instance.
  assign bus0.req       = bus8.req;
  assign bus0.req_write = bus8.req_write;
  assign bus0.req_x     = bus8.req_x;
  assign bus0.req_y     = bus8.req_y;
  assign bus0.req_color = bus8.req_color;

  vga_write_arbiter #(.NREQ(4), .nX(10), .nY(9), .CW(9), .MAX_HOLD(8), .IDXW(2)) dut8 (
    .Clock(clk), .Resetn(rst_n), .bus(bus8));
  vga_write_arbiter #(.NREQ(4), .nX(10), .nY(9), .CW(9), .MAX_HOLD(0), .IDXW(2)) dut0 (
    .Clock(clk), .Resetn(rst_n), .bus(bus0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pixel(input int i, input logic [9:0] x, input logic [8:0] y,
                           input logic [8:0] c);
    bus8.req_x[i*10 +: 10]    = x;
    bus8.req_y[i*9 +: 9]      = y;
    bus8.req_color[i*9 +: 9]  = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus8.req = '0; bus8.req_write = '0;
    bus8.req_x = '0; bus8.req_y = '0; bus8.req_color = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus8.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus8.gnt); end
    checks++; if ({bus8.VGA_x, bus8.VGA_y, bus8.VGA_color, bus8.VGA_write} !== 29'd0) begin errors++; $display("FAIL reset_vga: got %h/%h/%h/%b want 0", bus8.VGA_x, bus8.VGA_y, bus8.VGA_color, bus8.VGA_write); end
    checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
    checks++; if (bus8.owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d want 3", bus8.owner); end
    checks++; if ({bus8.timeout, bus8.drop_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus8.timeout, bus8.drop_err}); end
  endtask

  task automatic test_single_burst();
    do_reset();
    bus8.req = 4'b0001;
    set_pixel(0, 10'd5, 9'd7, 9'h1FF);
    tick();
    checks++; if (bus8.gnt !== 4'b0001) begin errors++; $display("FAIL burst_gnt: got %b want 0001", bus8.gnt); end
    checks++; if (bus8.VGA_write !== 1'b0) begin errors++; $display("FAIL burst_nowrite: got %b want 0", bus8.VGA_write); end
    bus8.req_write = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if ({bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color} !== {1'b1, 10'd5, 9'd7, 9'h1FF}) begin errors++; $display("FAIL burst_pix%0d: got %b %0d %0d %h want 1 5 7 1ff", n, bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color); end
    end
    bus8.req_write = 4'b0000;
    bus8.req = 4'b0000;
    tick();
    checks++; if ({bus8.busy, bus8.gnt, bus8.VGA_write} !== {1'b1, 4'b0000, 1'b0}) begin errors++; $display("FAIL burst_release: got busy=%b gnt=%b wr=%b want 1 0000 0", bus8.busy, bus8.gnt, bus8.VGA_write); end
    tick();
    checks++; if ({bus8.busy, bus8.gnt} !== 5'b0_0000) begin errors++; $display("FAIL burst_idle: got busy=%b gnt=%b want 0 0000", bus8.busy, bus8.gnt); end
    checks++; if ({bus8.drop_err, bus8.owner} !== {1'b0, 2'd0}) begin errors++; $display("FAIL burst_owner: got err=%b owner=%0d want 0 0", bus8.drop_err, bus8.owner); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    int         ord [5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus8.req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << ord[g];
      checks++; if (bus8.gnt !== exp) begin errors++; $display("FAIL rr_gnt%0d: got %b want %b", g, bus8.gnt, exp); end
      tick();
      checks++; if (bus8.gnt !== exp) begin errors++; $display("FAIL rr_hold%0d: got %b want %b", g, bus8.gnt, exp); end
      bus8.req[ord[g]] = 1'b0;
      tick();
      checks++; if ({bus8.busy, bus8.gnt} !== 5'b1_0000) begin errors++; $display("FAIL rr_release%0d: got busy=%b gnt=%b want 1 0000", g, bus8.busy, bus8.gnt); end
      bus8.req[ord[g]] = 1'b1;
      tick();
      checks++; if ({bus8.busy, bus8.gnt} !== 5'b0_0000) begin errors++; $display("FAIL rr_idle%0d: got busy=%b gnt=%b want 0 0000", g, bus8.busy, bus8.gnt); end
      tick();
    end
    bus8.req = 4'b0000;
  endtask

  task automatic test_watchdog();
    do_reset();
    bus8.req = 4'b1100;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if ({bus8.gnt, bus8.timeout} !== {4'b0100, 1'b0}) begin errors++; $display("FAIL wd_grant%0d: got gnt=%b to=%b want 0100 0", c, bus8.gnt, bus8.timeout); end
    end
    tick();
    checks++; if ({bus8.gnt, bus8.timeout, bus8.busy} !== {4'b0000, 1'b1, 1'b1}) begin errors++; $display("FAIL wd_revoke: got gnt=%b to=%b busy=%b want 0000 1 1", bus8.gnt, bus8.timeout, bus8.busy); end
    checks++; if ({bus0.gnt, bus0.timeout} !== {4'b0100, 1'b0}) begin errors++; $display("FAIL wd_disabled: got gnt=%b to=%b want 0100 0", bus0.gnt, bus0.timeout); end
    tick();
    checks++; if ({bus8.gnt, bus8.timeout} !== {4'b0000, 1'b0}) begin errors++; $display("FAIL wd_pulse: got gnt=%b to=%b want 0000 0", bus8.gnt, bus8.timeout); end
    tick();
    checks++; if (bus8.gnt !== 4'b1000) begin errors++; $display("FAIL wd_next: got %b want 1000", bus8.gnt); end
    bus8.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_drop_err();
    do_reset();
    bus8.req = 4'b0001;
    set_pixel(1, 10'd100, 9'd50, 9'h033);
    tick();
    checks++; if (bus8.drop_err !== 1'b0) begin errors++; $display("FAIL drop_pre: got %b want 0", bus8.drop_err); end
    bus8.req_write = 4'b0010;
    tick();
    checks++; if ({bus8.VGA_write, bus8.drop_err} !== 2'b01) begin errors++; $display("FAIL drop_set: got wr=%b err=%b want 0 1", bus8.VGA_write, bus8.drop_err); end
    bus8.req_write = 4'b0000;
    bus8.req = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
    checks++; if (bus8.drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", bus8.drop_err); end
    do_reset();
    checks++; if (bus8.drop_err !== 1'b0) begin errors++; $display("FAIL drop_clear: got %b want 0", bus8.drop_err); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus8.req = 4'b0100;
    set_pixel(2, 10'd300, 9'd200, 9'h155);
    tick();
    bus8.req_write = 4'b0100;
    tick();
    checks++; if (bus8.VGA_write !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", bus8.VGA_write); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus8.gnt, bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color, bus8.busy} !== 34'd0) begin errors++; $display("FAIL arst_now: got gnt=%b wr=%b %0d %0d %h busy=%b want all 0", bus8.gnt, bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color, bus8.busy); end
    bus8.req_write = 4'b0000;
    bus8.req = 4'b1111;
    tick();
    checks++; if ({bus8.gnt, bus8.VGA_write} !== 5'd0) begin errors++; $display("FAIL arst_hold: got gnt=%b wr=%b want 0000 0", bus8.gnt, bus8.VGA_write); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus8.gnt !== 4'b0001) begin errors++; $display("FAIL arst_prio: got %b want 0001", bus8.gnt); end
    bus8.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_last_write();
    do_reset();
    bus8.req = 4'b1000;
    set_pixel(3, 10'd639, 9'd479, 9'h0A5);
    tick();
    checks++; if (bus8.gnt !== 4'b1000) begin errors++; $display("FAIL last_gnt: got %b want 1000", bus8.gnt); end
    bus8.req_write = 4'b1000;
    tick();
    checks++; if ({bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color} !== {1'b1, 10'd639, 9'd479, 9'h0A5}) begin errors++; $display("FAIL last_pix: got %b %0d %0d %h want 1 639 479 0a5", bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color); end
    bus8.req_write = 4'b0000;
    bus8.req = 4'b0000;
    tick();
    checks++; if ({bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color} !== {1'b0, 10'd639, 9'd479, 9'h0A5}) begin errors++; $display("FAIL last_gap: got %b %0d %0d %h want 0 639 479 0a5", bus8.VGA_write, bus8.VGA_x, bus8.VGA_y, bus8.VGA_color); end
    tick();
    tick();
    checks++; if ({bus8.VGA_write, bus8.owner, bus8.VGA_x} !== {1'b0, 2'd3, 10'd639}) begin errors++; $display("FAIL last_idle: got wr=%b owner=%0d x=%0d want 0 3 639", bus8.VGA_write, bus8.owner, bus8.VGA_x); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_watchdog();
    test_drop_err();
    test_async_reset();
    test_last_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
